// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bundle: PC redirect in, instruction-memory request/response, and the decode handshake.
// The master modport is the fetch unit; the slave modport is its environment (execute, memory, decode).
interface fetch_queue_unit_if #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic [CW-1:0]   queue_count;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr, queue_count
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, queue_count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC register, one-cycle-latency imem request and a DEPTH-entry
// prefetch queue toward decode, with redirect/flush and credit-based back-pressure.
module fetch_queue_unit #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_queue_unit_if.master   bus
);
    localparam int              PW  = $clog2(DEPTH);
    localparam int              CW  = PW + 1;
    localparam logic [XLEN-1:0] INC = XLEN'(ILEN / 8);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic [CW-1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          out_valid;

    // Credit: a request is only issued if its response is guaranteed a free slot.
    assign occupancy = count_q + CW'(inflight_q);
    assign issue     = !rst && !bus.redirect_valid && (occupancy < CW'(DEPTH));
    assign push      = inflight_q && !bus.redirect_valid;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + INC;
            end
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage carries no reset; only count/head/tail qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= inflight_pc_q;
            instr_mem[tail_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = pc_mem[head_q];
    assign bus.out_instr   = instr_mem[head_q];
    assign bus.queue_count = count_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: queue-level reference model checked every cycle,
// plus literal expectations at the points of interest (reset, stall, redirect, wrap, reset mid-stream).
module tb_fetch_queue_unit;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int DEPTH = 4;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] scr;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue_unit_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus  ();
    fetch_queue_unit_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus2 ();

    fetch_queue_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_queue_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    always #5 clk = ~clk;

    // Memory returns (address ^ scr) one cycle after the request.
    always @(posedge clk) begin
        bus.imem_rdata  <= bus.imem_addr[31:0] ^ scr;
        bus2.imem_rdata <= bus2.imem_addr[31:0];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Reference model: fetch PC, queue of fetched PCs, one outstanding request.
    logic [63:0] m_pc;
    logic [63:0] m_infl_pc;
    bit          m_infl;
    logic [63:0] mq[$];

    initial begin
        bit e_req;
        bit e_valid;
        m_pc      = 64'd0;
        m_infl    = 1'b0;
        m_infl_pc = 64'd0;
        mq.delete();
        forever begin
            @(negedge clk);
            e_req   = !rst && !bus.redirect_valid && ((mq.size() + int'(m_infl)) < DEPTH);
            e_valid = (mq.size() != 0);
            chk("m_imem_req", 64'(bus.imem_req), 64'(e_req));
            if (!rst) begin
                chk("m_imem_addr", bus.imem_addr, m_pc);
                chk("m_out_valid", 64'(bus.out_valid), 64'(e_valid));
                chk("m_queue_count", 64'(bus.queue_count), 64'(mq.size()));
                if (e_valid) begin
                    chk("m_out_pc", bus.out_pc, mq[0]);
                    chk("m_out_instr", 64'(bus.out_instr), 64'(mq[0][31:0] ^ scr));
                end
            end
            if (rst) begin
                m_pc   = 64'd0;
                m_infl = 1'b0;
                mq.delete();
            end else if (bus.redirect_valid) begin
                m_pc   = {bus.redirect_pc[63:2], 2'b00};
                m_infl = 1'b0;
                mq.delete();
            end else begin
                if (e_valid && bus.out_ready) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_infl_pc);
                if (e_req) begin
                    m_infl    = 1'b1;
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + 64'd4;
                end else begin
                    m_infl = 1'b0;
                end
            end
        end
    end

    logic [63:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        wrap_exp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        wrap_exp[2] = 64'h0000_0000_0000_0000;
        wrap_exp[3] = 64'h0000_0000_0000_0004;

        rst = 1'b1;
        scr = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.out_ready      = 1'b1;

        // Reset release, streaming with out_ready high
        tick(); rst = 1'b0;
        neg();
        chk("c1_imem_req", 64'(bus.imem_req), 64'd1);
        chk("c1_imem_addr", bus.imem_addr, 64'd0);
        chk("c1_out_valid", 64'(bus.out_valid), 64'd0);
        chk("c1_count", 64'(bus.queue_count), 64'd0);
        tick(); neg();
        chk("c2_out_valid", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); neg();
            chk("stream_valid", 64'(bus.out_valid), 64'd1);
            chk("stream_pc", bus.out_pc, 64'(k * 4));
            chk("stream_instr", 64'(bus.out_instr), 64'(k * 4));
            chk("wrap_pc", bus2.out_pc, wrap_exp[k]);
        end
        repeat (4) tick();

        // Back-pressure: hold out_ready low for 10 cycles, then drain
        rst = 1'b1; bus.out_ready = 1'b0; scr = 32'h5A5A_0000;
        tick(); rst = 1'b0;
        repeat (9) tick();
        neg();
        chk("stall_count", 64'(bus.queue_count), 64'd4);
        chk("stall_imem_req", 64'(bus.imem_req), 64'd0);
        tick(); bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            neg();
            chk("drain_valid", 64'(bus.out_valid), 64'd1);
            chk("drain_pc", bus.out_pc, 64'(k * 4));
            chk("drain_instr", 64'(bus.out_instr), 64'(32'(k * 4) ^ 32'h5A5A_0000));
            tick();
        end

        // Redirect to 0x1002 with count=3 and a request in flight
        rst = 1'b1; bus.out_ready = 1'b0;
        tick(); rst = 1'b0;
        repeat (4) tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h1002;
        neg();
        chk("redir_pre_count", 64'(bus.queue_count), 64'd3);
        chk("redir_imem_req", 64'(bus.imem_req), 64'd0);
        tick(); bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
        neg();
        chk("redir_r1_count", 64'(bus.queue_count), 64'd0);
        chk("redir_r1_valid", 64'(bus.out_valid), 64'd0);
        chk("redir_r1_addr", bus.imem_addr, 64'h1000);
        chk("redir_r1_req", 64'(bus.imem_req), 64'd1);
        tick(); neg();
        chk("redir_r2_valid", 64'(bus.out_valid), 64'd0);
        tick(); neg();
        chk("redir_r3_valid", 64'(bus.out_valid), 64'd1);
        chk("redir_r3_pc", bus.out_pc, 64'h1000);
        repeat (6) tick();

        // Redirect held three cycles, first cycle coincides with pop and response
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h2000;
        neg();
        chk("rpop_valid", 64'(bus.out_valid), 64'd1);
        chk("rpop_count", 64'(bus.queue_count), 64'd1);
        for (int k = 0; k < 2; k++) begin
            tick(); neg();
            chk("rhold_count", 64'(bus.queue_count), 64'd0);
            chk("rhold_valid", 64'(bus.out_valid), 64'd0);
            chk("rhold_req", 64'(bus.imem_req), 64'd0);
        end
        tick(); bus.redirect_valid = 1'b0; bus.out_ready = 1'b0;
        neg();
        chk("rrel_addr", bus.imem_addr, 64'h2000);
        chk("rrel_req", 64'(bus.imem_req), 64'd1);

        // Reset mid-stream with three entries queued
        repeat (4) tick();
        rst = 1'b1;
        neg();
        chk("rstmid_pre_count", 64'(bus.queue_count), 64'd3);
        tick(); rst = 1'b0; bus.out_ready = 1'b1;
        neg();
        chk("rstmid_valid", 64'(bus.out_valid), 64'd0);
        chk("rstmid_count", 64'(bus.queue_count), 64'd0);
        chk("rstmid_addr", bus.imem_addr, 64'd0);
        tick(); tick(); neg();
        chk("rstmid_first_valid", 64'(bus.out_valid), 64'd1);
        chk("rstmid_first_pc", bus.out_pc, 64'd0);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
